// File: rtl/waveform_uart_tx.sv
// rtl/waveform_uart_tx.sv - snapshots a 32-sample waveform and pulse height, sends them as a checksummed UART 8N1 frame
module waveform_uart_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        longTrigger,
   input  logic [13:0] waveform [0:31],
   input  logic [13:0] pulseHeight,
   output logic        tx,
   output logic        busy,
   output logic [7:0]  droppedFrames
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   localparam logic [6:0] LAST_BYTE = 7'd67;
   localparam logic [7:0] HEADER    = 8'hA5;

   state_t      r_state;
   logic        r_trig_d;
   logic [13:0] r_wave [0:31];
   logic [13:0] r_ph;
   logic [7:0]  r_shift;
   logic [7:0]  r_csum;
   logic [15:0] r_bit_timer;
   logic [2:0]  r_bit_index;
   logic [6:0]  r_byte_index;
   logic        r_tx;
   logic        r_busy;
   logic [7:0]  r_dropped;

   logic        w_capture;
   logic        w_bit_done;
   logic [6:0]  w_next_index;
   logic [5:0]  w_sample_off;
   logic [13:0] w_sample;
   logic [7:0]  w_next_byte;

   // Falling edge of longTrigger marks a completed capture.
   assign w_capture    = r_trig_d & ~longTrigger;
   assign w_bit_done   = (r_bit_timer == 16'(CLKS_PER_BIT - 1));
   assign w_next_index = r_byte_index + 7'd1;
   // Bytes 3..66 map to sample (idx-3)/2; even offset is the high byte.
   assign w_sample_off = w_next_index[5:0] - 6'd3;
   assign w_sample     = r_wave[w_sample_off[5:1]];

   assign tx            = r_tx;
   assign busy          = r_busy;
   assign droppedFrames = r_dropped;

   // Select the frame byte that will be loaded next, after the current one finishes.
   always_comb begin
      w_next_byte = 8'h00;
      if (w_next_index == 7'd1) begin
         w_next_byte = {2'b00, r_ph[13:8]};
      end else if (w_next_index == 7'd2) begin
         w_next_byte = r_ph[7:0];
      end else if (w_next_index == LAST_BYTE) begin
         w_next_byte = r_csum;
      end else if (w_sample_off[0] == 1'b0) begin
         w_next_byte = {2'b00, w_sample[13:8]};
      end else begin
         w_next_byte = w_sample[7:0];
      end
   end

   // Snapshot buffer: loaded only when an idle capture is accepted, so later input changes are ignored.
   always_ff @(posedge clk) begin
      if (!reset && w_capture && !r_busy) begin
         r_ph <= pulseHeight;
         for (int i = 0; i < 32; i++) begin
            r_wave[i] <= waveform[i];
         end
      end
   end

   // Edge detect, overrun counter and the serializer state machine.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_trig_d     <= 1'b0;
         r_shift      <= 8'h00;
         r_csum       <= 8'h00;
         r_bit_timer  <= 16'd0;
         r_bit_index  <= 3'd0;
         r_byte_index <= 7'd0;
         r_tx         <= 1'b1;
         r_busy       <= 1'b0;
         r_dropped    <= 8'd0;
      end else begin
         r_trig_d <= longTrigger;

         if (w_capture && r_busy && (r_dropped != 8'hFF)) begin
            r_dropped <= r_dropped + 8'd1;
         end

         case (r_state)
            S_IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               if (w_capture) begin
                  r_state      <= S_START;
                  r_busy       <= 1'b1;
                  r_tx         <= 1'b0;
                  r_shift      <= HEADER;
                  r_csum       <= 8'h00;
                  r_bit_timer  <= 16'd0;
                  r_byte_index <= 7'd0;
               end
            end

            S_START: begin
               if (w_bit_done) begin
                  r_bit_timer <= 16'd0;
                  r_bit_index <= 3'd0;
                  r_tx        <= r_shift[0];
                  r_state     <= S_DATA;
               end else begin
                  r_bit_timer <= r_bit_timer + 16'd1;
               end
            end

            S_DATA: begin
               if (w_bit_done) begin
                  r_bit_timer <= 16'd0;
                  if (r_bit_index == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit_index <= r_bit_index + 3'd1;
                     r_shift     <= {1'b0, r_shift[7:1]};
                     r_tx        <= r_shift[1];
                  end
               end else begin
                  r_bit_timer <= r_bit_timer + 16'd1;
               end
            end

            S_STOP: begin
               if (w_bit_done) begin
                  r_bit_timer <= 16'd0;
                  if (r_byte_index < LAST_BYTE) begin
                     r_byte_index <= w_next_index;
                     r_shift      <= w_next_byte;
                     // The checksum itself is not folded into the running XOR.
                     if (w_next_index != LAST_BYTE) begin
                        r_csum <= r_csum ^ w_next_byte;
                     end
                     r_tx    <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_bit_timer <= r_bit_timer + 16'd1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_waveform_uart_tx.sv
// tb/tb_waveform_uart_tx.sv - directed scoreboard bench for waveform_uart_tx
module tb_waveform_uart_tx;

   localparam int N = 4;

   logic        clk;
   logic        reset;
   logic        longTrigger;
   logic [13:0] wave_in [0:31];
   logic [13:0] ph_in;
   logic        tx;
   logic        busy;
   logic [7:0]  droppedFrames;

   int tests = 0;
   int fails = 0;
   int gen   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];

   waveform_uart_tx #(.CLKS_PER_BIT(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .longTrigger  (longTrigger),
      .waveform     (wave_in),
      .pulseHeight  (ph_in),
      .tx           (tx),
      .busy         (busy),
      .droppedFrames(droppedFrames)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected frame from the current input values.
   task automatic push_frame();
      logic [7:0] c;
      logic [7:0] b;
      c = 8'h00;
      exp_q.push_back(8'hA5);
      b = {2'b00, ph_in[13:8]}; exp_q.push_back(b); c = c ^ b;
      b = ph_in[7:0];           exp_q.push_back(b); c = c ^ b;
      for (int i = 0; i < 32; i++) begin
         b = {2'b00, wave_in[i][13:8]}; exp_q.push_back(b); c = c ^ b;
         b = wave_in[i][7:0];           exp_q.push_back(b); c = c ^ b;
      end
      exp_q.push_back(c);
   endtask

   task automatic pulse();
      @(negedge clk) longTrigger = 1'b1;
      @(negedge clk) longTrigger = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check(tag, (n < 4000), 1'b1);
      repeat (5) @(negedge clk);
   endtask

   // UART receiver: decodes bytes at mid-bit and checks them against the scoreboard.
   logic [7:0] m_byte;
   logic       m_stop;
   int         m_gen;
   initial begin
      forever begin
         @(negedge clk);
         if (tx === 1'b0 && reset === 1'b0) begin
            m_gen = gen;
            repeat (N + N / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               m_byte[i] = tx;
               if (i < 7) repeat (N) @(negedge clk);
            end
            repeat (N) @(negedge clk);
            m_stop = tx;
            if (m_gen == gen) begin
               rx_log.push_back(m_byte);
               check("stop_bit", m_stop, 1'b1);
               check("rx_expected_pending", (exp_q.size() != 0), 1'b1);
               if (exp_q.size() != 0) begin
                  check("rx_byte", m_byte, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hi;
      reset = 1'b1;
      longTrigger = 1'b0;
      ph_in = 14'd0;
      for (int i = 0; i < 32; i++) wave_in[i] = 14'd0;

      // Reset
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_dropped", droppedFrames, 8'd0);
      hi = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) hi++;
      end
      check("idle_tx_low_cycles", hi, 0);

      // Basic frame
      ph_in = 14'h1234;
      rx_log.delete();
      push_frame();
      check("basic_pre_busy", busy, 1'b0);
      pulse();
      @(negedge clk);
      check("basic_start_bit", tx, 1'b0);
      check("basic_busy_rise", busy, 1'b1);
      n = 1;
      while (busy === 1'b1 && n < 3000) begin
         @(negedge clk);
         if (busy === 1'b1) n++;
      end
      check("basic_busy_cycles", n, 2720);
      repeat (5) @(negedge clk);
      check("basic_bytes", rx_log.size(), 68);
      check("basic_checksum", rx_log[67], 8'h26);
      check("basic_queue_empty", exp_q.size(), 0);

      // Sample ordering
      ph_in = 14'h3FFF;
      for (int i = 0; i < 32; i++) wave_in[i] = 14'(i);
      rx_log.delete();
      push_frame();
      pulse();
      @(negedge clk);
      wait_idle("order_idle");
      check("order_bytes", rx_log.size(), 68);
      check("order_ph_hi", rx_log[1], 8'h3F);
      check("order_ph_lo", rx_log[2], 8'hFF);
      check("order_s31_lo", rx_log[66], 8'h1F);
      check("order_checksum", rx_log[67], 8'hC0);
      check("order_queue_empty", exp_q.size(), 0);

      // Input isolation
      ph_in = 14'($urandom_range(0, 16383));
      for (int i = 0; i < 32; i++) wave_in[i] = 14'($urandom_range(0, 16383));
      rx_log.delete();
      push_frame();
      pulse();
      @(negedge clk);
      n = 0;
      while (busy === 1'b1 && n < 4000) begin
         ph_in = 14'($urandom_range(0, 16383));
         for (int i = 0; i < 32; i++) wave_in[i] = 14'($urandom_range(0, 16383));
         @(negedge clk);
         n++;
      end
      check("iso_finished", (n < 4000), 1'b1);
      repeat (5) @(negedge clk);
      check("iso_bytes", rx_log.size(), 68);
      check("iso_queue_empty", exp_q.size(), 0);

      // Overrun
      rx_log.delete();
      push_frame();
      pulse();
      repeat (100) @(negedge clk);
      pulse();
      @(negedge clk);
      check("drop_first", droppedFrames, 8'd1);
      for (int i = 0; i < 300; i++) pulse();
      @(negedge clk);
      check("drop_saturate", droppedFrames, 8'd255);
      check("drop_still_busy", busy, 1'b1);
      wait_idle("drop_idle");
      hi = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy !== 1'b0) hi++;
      end
      check("drop_no_second_frame", hi, 0);
      check("drop_bytes", rx_log.size(), 68);
      check("drop_queue_empty", exp_q.size(), 0);
      check("drop_hold", droppedFrames, 8'd255);

      // Reset mid-frame
      rx_log.delete();
      push_frame();
      pulse();
      n = 0;
      while (rx_log.size() < 10 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("mid_reached_byte10", (n < 2000), 1'b1);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      gen++;
      exp_q.delete();
      @(negedge clk);
      check("mid_reset_tx", tx, 1'b1);
      check("mid_reset_busy", busy, 1'b0);
      check("mid_reset_dropped", droppedFrames, 8'd0);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      ph_in = 14'h2A5C;
      for (int i = 0; i < 32; i++) wave_in[i] = 14'(16383 - 3 * i);
      rx_log.delete();
      push_frame();
      pulse();
      @(negedge clk);
      check("mid_restart_busy", busy, 1'b1);
      wait_idle("mid_idle");
      check("mid_bytes", rx_log.size(), 68);
      check("mid_header", rx_log[0], 8'hA5);
      check("mid_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
